// File: rtl/ring_ctrl_pkg.sv
// Shared types and helpers for the ring-oscillator measurement controller.
package ring_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWarmup  = 2'd1,
      StMeasure = 2'd2,
      StDone    = 2'd3
   } state_e;

   localparam int unsigned WARMUP_DEF    = 16;
   localparam int unsigned GATE_BASE_DEF = 8;
   localparam int unsigned GATE_SEL_W    = 3;

   // Gate window length in clk cycles for a given base exponent and selector.
   function automatic int unsigned window_len(input int unsigned gate_base,
                                              input logic [GATE_SEL_W-1:0] gate_sel);
      return 32'd1 << (gate_base + 32'(gate_sel));
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge pulse.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   // sync_q[0..1] form the synchronizer, sync_q[2] holds the previous synced value.
   logic [2:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Ring-oscillator frequency measurement: warm up the ring, count divided edges over a
// programmable gate window, latch the result and shut the ring down.
module ring_osc_meas_ctrl
   import ring_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned GATE_BASE = GATE_BASE_DEF,
   parameter int unsigned WARMUP    = WARMUP_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [GATE_SEL_W-1:0] gate_sel,
   input  logic                  osc_in,
   output logic                  ring_en,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow
);

   localparam int unsigned TMR_W = GATE_BASE + 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e                state_q, state_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic [GATE_SEL_W-1:0] gsel_q, gsel_d;
   logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
   logic                  sat_q, sat_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  done_q, done_d;
   logic                  rise;

   sync_edge_det u_sync_edge_det (
      .clk      (clk),
      .rst      (rst),
      .async_in (osc_in),
      .rise     (rise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         gsel_q     <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         gsel_q     <= gsel_d;
         edge_cnt_q <= edge_cnt_d;
         sat_q      <= sat_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      gsel_d     = gsel_q;
      edge_cnt_d = edge_cnt_q;
      sat_d      = sat_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;

      if (state_q == StMeasure && rise) begin
         if (edge_cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
         end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               gsel_d  = gate_sel;
               timer_d = TMR_W'(WARMUP - 1);
               state_d = StWarmup;
            end
         end
         StWarmup: begin
            if (abort) begin
               state_d = StIdle;
            end else if (timer_q == '0) begin
               edge_cnt_d = '0;
               sat_d      = 1'b0;
               timer_d    = TMR_W'(window_len(GATE_BASE, gsel_q) - 1);
               state_d    = StMeasure;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         StMeasure: begin
            if (abort) begin
               state_d = StIdle;
            end else if (timer_q == '0) begin
               // Result registers load here so they are visible alongside done in StDone.
               count_d = edge_cnt_d;
               ovf_d   = sat_d;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign ring_en  = (state_q == StWarmup) || (state_q == StMeasure);
   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Randomized self-checking bench for ring_osc_meas_ctrl against a cycle-window model.
module tb_ring_osc_meas_ctrl;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned GB    = 8;
   localparam int unsigned WU    = 16;
   localparam int          NCYC  = 40000;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [2:0]       gate_sel;
   logic             osc_in;
   logic             ring_en;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             overflow;

   ring_osc_meas_ctrl #(
      .CNT_W     (CNT_W),
      .GATE_BASE (GB),
      .WARMUP    (WU)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .gate_sel (gate_sel),
      .osc_in   (osc_in),
      .ring_en  (ring_en),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: osc_in sampled at each edge is recorded; a measurement started at edge T
   // occupies cycles T..D with D = T + WU + window, DONE being cycle D. An osc rise
   // first sampled at edge k becomes a pulse consumed at edge k+2, counted if that
   // edge closes a MEASURE cycle (edges T+WU+1 .. T+WU+window).
   int   cyc = 0;
   logic hist [NCYC];
   bit   m_act = 1'b0;
   int   m_t, m_d;
   int   exp_count = 0;
   bit   exp_ovf = 1'b0, exp_busy = 1'b0, exp_ring = 1'b0, exp_done = 1'b0;

   always @(posedge clk) begin
      int sum;
      cyc++;
      if (cyc < NCYC) hist[cyc] = osc_in;
      if (rst) begin
         m_act     = 1'b0;
         exp_count = 0;
         exp_ovf   = 1'b0;
      end else if (m_act) begin
         if (cyc == m_d + 1 || abort) m_act = 1'b0;
      end else if (start && !abort) begin
         m_act = 1'b1;
         m_t   = cyc;
         m_d   = cyc + int'(WU) + (1 << (GB + gate_sel));
      end
      exp_busy = m_act;
      exp_ring = m_act && (cyc < m_d);
      exp_done = m_act && (cyc == m_d);
      if (exp_done) begin
         sum = 0;
         for (int e = m_t + int'(WU) + 1; e <= m_d; e++) begin
            if (e < NCYC && hist[e-2] && !hist[e-3]) sum++;
         end
         exp_count = (sum > CMAX) ? CMAX : sum;
         exp_ovf   = (sum > CMAX);
      end
   end

   int busy_cyc = 0, ring_cyc = 0, done_cnt = 0;

   always begin
      @(posedge clk);
      #1;
      if (cyc >= 1) begin
         chk("busy", busy, exp_busy);
         chk("ring_en", ring_en, exp_ring);
         chk("done", done, exp_done);
         chk("count", count, exp_count);
         chk("overflow", overflow, exp_ovf);
      end
      if (busy) busy_cyc++;
      if (ring_en) ring_cyc++;
      if (done) done_cnt++;
   end

   // osc modes: 0 held low, 1 period 4, 2 toggle every cycle, 3 random
   int osc_mode = 0;
   int ph = 0;
   initial begin
      osc_in = 1'b0;
      forever begin
         @(negedge clk);
         ph++;
         case (osc_mode)
            0:       osc_in = 1'b0;
            1:       osc_in = ph[1];
            2:       osc_in = ~osc_in;
            default: osc_in = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         tick(1);
         seen = done;
      end
      chk(name, seen, 1);
   endtask

   task automatic meas(input logic [2:0] gs, input int mode, output int db, output int dr,
                       output int dd);
      int b0, r0, d0;
      b0 = busy_cyc;
      r0 = ring_cyc;
      d0 = done_cnt;
      osc_mode = mode;
      gate_sel = gs;
      start    = 1'b1;
      tick(1);
      start = 1'b0;
      wait_done("done_timeout");
      tick(2);
      db = busy_cyc - b0;
      dr = ring_cyc - r0;
      dd = done_cnt - d0;
   endtask

   initial begin
      int db, dr, dd, b0, d0;
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      gate_sel = 3'd0;
      tick(3);
      rst = 1'b0;
      tick(2);
      chk("reset_count", count, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ring_en", ring_en, 0);

      // Idle ring: 273 busy cycles, zero count
      meas(3'd0, 0, db, dr, dd);
      chk("t1_busy_len", db, 273);
      chk("t1_ring_len", dr, 272);
      chk("t1_dones", dd, 1);
      chk("t1_count", count, 0);
      chk("t1_ovf", overflow, 0);
      chk("t1_ring_off", ring_en, 0);

      // One rise every 4 cycles over 256 cycles
      meas(3'd0, 1, db, dr, dd);
      chk("t2_count", count, 64);
      chk("t2_ovf", overflow, 0);
      chk("t2_ring_len", dr, 272);

      // Saturation with 512 rises in a 1024-cycle window
      meas(3'd2, 2, db, dr, dd);
      chk("t3_busy_len", db, int'(WU) + 1024 + 1);
      chk("t3_count", count, 255);
      chk("t3_ovf", overflow, 1);

      // Abort mid-MEASURE after a prior result of 64
      meas(3'd0, 1, db, dr, dd);
      chk("t4_prior", count, 64);
      d0    = done_cnt;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(int'(WU) + 100);
      chk("t4_in_measure", ring_en, 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t4_abort_busy", busy, 0);
      chk("t4_abort_ring", ring_en, 0);
      tick(300);
      chk("t4_no_done", done_cnt - d0, 0);
      chk("t4_count_held", count, 64);

      // start re-pulsed and gate_sel changed mid-run are ignored
      b0       = busy_cyc;
      d0       = done_cnt;
      gate_sel = 3'd0;
      start    = 1'b1;
      tick(1);
      start = 1'b0;
      tick(int'(WU) + 50);
      start    = 1'b1;
      gate_sel = 3'd3;
      tick(1);
      start = 1'b0;
      wait_done("t5_done_timeout");
      tick(2);
      chk("t5_busy_len", busy_cyc - b0, 273);
      chk("t5_dones", done_cnt - d0, 1);

      // Reset mid-WARMUP, then a full measurement
      gate_sel = 3'd0;
      start    = 1'b1;
      tick(1);
      start = 1'b0;
      tick(5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_ring", ring_en, 0);
      chk("t6_done", done, 0);
      chk("t6_count", count, 0);
      chk("t6_ovf", overflow, 0);
      tick(3);
      meas(3'd1, 3, db, dr, dd);
      chk("t6_busy_len", db, int'(WU) + 512 + 1);
      chk("t6_dones", dd, 1);

      // Random runs: held start, random osc, occasional abort
      for (int it = 0; it < 10; it++) begin
         gate_sel = 3'($urandom_range(0, 1));
         osc_mode = $urandom_range(0, 3);
         start    = 1'b1;
         if ($urandom_range(0, 1) == 0) tick(1);
         else tick($urandom_range(2, 400));
         start = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            tick($urandom_range(0, 500));
            abort = 1'b1;
            tick(1);
            abort = 1'b0;
         end
         for (int i = 0; i < 1200 && busy; i++) tick(1);
         chk("rand_idle", busy, 0);
         tick(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
